// File: rtl/ro_puf_pkg.sv
// Shared definitions for the ring-oscillator edge counter: default widths,
// settle length and the measurement FSM state encoding.
`timescale 1ns/1ps
package ro_puf_pkg;

    localparam int CNT_W_DEF  = 16;
    localparam int WIN_W_DEF  = 16;
    localparam int SETTLE_LEN = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        COUNT  = 2'd2,
        DONE   = 2'd3
    } ro_state_e;

endpackage

// File: rtl/ro_sync_edge.sv
// Brings the asynchronous ring-oscillator output into clk through two flops,
// then produces a registered one-cycle pulse on each synchronized rising edge.
`timescale 1ns/1ps
module ro_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic ro_in,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= ro_in;
            sync2 <= sync1;
            prev  <= sync2;
            rise  <= sync2 & ~prev;
        end
    end

endmodule

// File: rtl/ro_edge_counter.sv
// Counts ro_in rising edges over a programmable window of clk cycles.
// Define RO_CNT_SAT_EN to saturate the count and report overflow on ovf;
// otherwise the count wraps and ovf is tied low.
//
// state  | meaning
// IDLE   | waiting for start; count/ovf hold the last result
// SETTLE | synchronizer pipeline flushing, edges discarded
// COUNT  | window open, detected edges are counted
// DONE   | one-cycle result strobe on done
`timescale 1ns/1ps
module ro_edge_counter
    import ro_puf_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ro_in,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    localparam logic [WIN_W-1:0] SETTLE_LAST = WIN_W'(SETTLE_LEN - 1);

    ro_state_e        state_q;
    ro_state_e        state_nxt;
    logic [WIN_W-1:0] tmr_q;
    logic [WIN_W-1:0] tmr_nxt;
    logic [WIN_W-1:0] win_q;
    logic             accept;
    logic             cnt_en;
    logic             rise;

    ro_sync_edge u_sync_edge (
        .clk   (clk),
        .rst   (rst),
        .ro_in (ro_in),
        .rise  (rise)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            done    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            tmr_q   <= tmr_nxt;
            done    <= (state_nxt == DONE);
        end
    end

    // One down-counter times both SETTLE and COUNT; phases end at terminal zero.
    always_comb begin
        state_nxt = state_q;
        tmr_nxt   = tmr_q;
        accept    = 1'b0;
        cnt_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    tmr_nxt   = SETTLE_LAST;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (tmr_q == '0) begin
                    if (win_q == '0) begin
                        state_nxt = DONE;
                    end else begin
                        tmr_nxt   = win_q - WIN_W'(1);
                        state_nxt = COUNT;
                    end
                end else begin
                    tmr_nxt = tmr_q - WIN_W'(1);
                end
            end
            COUNT: begin
                cnt_en = rise;
                if (tmr_q == '0) begin
                    state_nxt = DONE;
                end else begin
                    tmr_nxt = tmr_q - WIN_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q <= '0;
        end else if (accept) begin
            win_q <= win_len;
        end
    end

`ifdef RO_CNT_SAT_EN
    logic ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            count <= '0;
            ovf_q <= 1'b0;
        end else if (cnt_en) begin
            if (count == {CNT_W{1'b1}}) begin
                ovf_q <= 1'b1;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

    assign ovf = ovf_q;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (accept) begin
            count <= '0;
        end else if (cnt_en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_ro_edge_counter.sv
// Randomized bench for ro_edge_counter against a window-based edge-count model,
// plus directed cases with hand-computed results.
`timescale 1ns/1ps
module tb_ro_edge_counter;

    localparam int CNT_W = 4;
    localparam int WIN_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef RO_CNT_SAT_EN
    localparam bit SAT = 1'b1;
    localparam int LIT31_CNT = 15;
    localparam int LIT31_OVF = 1;
`else
    localparam bit SAT = 1'b0;
    localparam int LIT31_CNT = 4;
    localparam int LIT31_OVF = 0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ro_in = 1'b0;
    logic             start = 1'b0;
    logic [WIN_W-1:0] win_len = '0;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;
    logic             ovf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ro_edge_counter #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .ro_in   (ro_in),
        .start   (start),
        .win_len (win_len),
        .busy    (busy),
        .done    (done),
        .count   (count),
        .ovf     (ovf)
    );

    // ro_in source: 0 hold, 1 square wave with half-period ro_half, 2 random with >=2-cycle holds
    int ro_mode = 0;
    int ro_half = 2;
    int ro_ph   = 0;
    always @(posedge clk) begin
        #2;
        case (ro_mode)
            1: begin
                ro_ph++;
                if (ro_ph >= ro_half) begin ro_ph = 0; ro_in = ~ro_in; end
            end
            2: begin
                ro_ph++;
                if (ro_ph >= 2 && $urandom_range(0, 2) == 0) begin ro_ph = 0; ro_in = ~ro_in; end
            end
            default: ;
        endcase
    end

    // Model: a measurement accepted at edge T with window W counts every rising
    // transition of ro_in sampled between edges T-1..T+W-1 (observed 3 edges later),
    // reports done after edge T+W+2 and is idle again after edge T+W+3.
    int cyc = 0;
    bit hist [0:131071];
    bit m_active = 1'b0;
    int m_t = 0;
    int m_w = 0;
    int m_raw = 0;
    bit m_done = 1'b0;

    always @(posedge clk) begin
        cyc++;
        m_done = 1'b0;
        if (rst) begin
            hist[cyc] = 1'b0;
            m_active  = 1'b0;
            m_raw     = 0;
        end else begin
            hist[cyc] = ro_in;
            if (m_active) begin
                if (cyc == m_t + m_w + 3) begin
                    m_active = 1'b0;
                end else begin
                    if (cyc - 3 >= m_t && cyc - 3 <= m_t + m_w - 1 &&
                        hist[cyc-3] && !hist[cyc-4])
                        m_raw++;
                    if (cyc == m_t + m_w + 2) m_done = 1'b1;
                end
            end else if (start) begin
                m_active = 1'b1;
                m_t      = cyc;
                m_w      = int'(win_len);
                m_raw    = 0;
            end
        end
    end

    function automatic int exp_count(int raw);
        if (SAT) return (raw > CMAX) ? CMAX : raw;
        return raw % (CMAX + 1);
    endfunction

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    int done_n = 0;
    int last_done = 0;
    always @(negedge clk) begin
        int e_busy, e_done, e_cnt, e_ovf;
        if (rst) begin
            e_busy = 0; e_done = 0; e_cnt = 0; e_ovf = 0;
        end else begin
            e_busy = int'(m_active);
            e_done = int'(m_done);
            e_cnt  = exp_count(m_raw);
            e_ovf  = (SAT && m_raw > CMAX) ? 1 : 0;
        end
        chk("busy",  int'(busy),  e_busy);
        chk("done",  int'(done),  e_done);
        chk("count", int'(count), e_cnt);
        chk("ovf",   int'(ovf),   e_ovf);
        if (done) begin
            done_n++;
            last_done = cyc;
        end
    end

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Launch one measurement; optionally re-pulse start (win_len=8) poke cycles later.
    task automatic measure(input int w, input int poke, output int t, output int dcyc);
        int d0;
        d0 = done_n;
        start = 1'b1;
        win_len = WIN_W'(w);
        tick(1);
        t = cyc;
        start = 1'b0;
        for (int i = 1; i < w + 20 && done_n == d0; i++) begin
            start = (i == poke);
            if (i == poke) win_len = WIN_W'(8);
            tick(1);
        end
        start = 1'b0;
        if (done_n == d0) tick(2);
        chk("done_seen", done_n - d0, 1);
        dcyc = last_done;
        tick(2);
    endtask

    initial begin
        int t, d, d2;
        tick(3);
        rst = 1'b0;
        tick(3);
        chk("rst_busy", int'(busy), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_done", int'(done), 0);

        // ro_in toggling every 4 cycles, 64-cycle window
        ro_mode = 1; ro_half = 4;
        measure(64, 0, t, d);
        chk("w64_done_t", d - t, 66);
        chk("w64_cnt_range", (count >= 7 && count <= 9) ? 1 : 0, 1);
        chk("w64_ovf", int'(ovf), 0);

        // zero window
        measure(0, 0, t, d);
        chk("w0_done_t", d - t, 2);
        chk("w0_cnt", int'(count), 0);
        chk("w0_ovf", int'(ovf), 0);

        // period 4, 80-cycle window: 20 edges
        ro_half = 2;
        measure(80, 0, t, d);
        chk("w80_cnt", int'(count), LIT31_CNT);
        chk("w80_ovf", int'(ovf), LIT31_OVF);
        chk("w80_done_t", d - t, 82);

        // start pulsed again mid-COUNT
        measure(40, 12, t, d);
        chk("poke_done_t", d - t, 42);
        chk("poke_cnt", int'(count), 10);

        // constant ro_in, 100-cycle window
        ro_mode = 0;
        measure(100, 0, t, d);
        chk("w100_done_t", d - t, 102);
        chk("w100_cnt", int'(count), 0);

        // reset in mid-COUNT at count=5
        ro_mode = 1; ro_half = 2;
        start = 1'b1; win_len = WIN_W'(60);
        tick(1);
        start = 1'b0;
        for (int i = 0; i < 200 && count != 5; i++) tick(1);
        chk("reach5", int'(count), 5);
        d = done_n;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_count", int'(count), 0);
        tick(1);
        rst = 1'b0;
        tick(70);
        chk("mid_rst_nodone", done_n - d, 0);
        measure(20, 0, t, d);
        chk("post_rst_cnt", int'(count), 5);
        chk("post_rst_done_t", d - t, 22);

        // start held through DONE into the following IDLE
        d = done_n;
        start = 1'b1; win_len = WIN_W'(10);
        for (int i = 0; i < 60 && done_n < d + 2; i++) tick(1);
        start = 1'b0;
        chk("hold_two_dones", done_n - d, 2);
        d2 = last_done;
        tick(20);

        // randomized measurements
        for (int k = 0; k < 30; k++) begin
            int w, p;
            ro_mode = $urandom_range(0, 2);
            ro_half = $urandom_range(2, 5);
            w = $urandom_range(0, 45);
            p = (w > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(1, w + 1) : 0;
            measure(w, p, t, d);
            chk("rand_done_t", d - t, w + 2);
        end

        tick(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
